base_askid: RTL and testbench



---
 rtl/base_askid_pkg.sv | 11 +
 rtl/base_askid.sv | 82 ++++++++
 tb/tb_base_askid.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/base_askid_pkg.sv
// Shared definitions for the base_askid skid stage.
// State encodings equal the number of held beats, so occupancy is the state itself.
package base_askid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } askid_state_e;

endpackage

// File: rtl/base_askid.sv
// Two-entry registered valid/ready skid stage: breaks the combinational ready path
// from the downstream force stage while sustaining one beat per cycle.
module base_askid
    import base_askid_pkg::*;
#(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             i_v,
    output logic             i_r,
    input  logic [0:width-1] i_d,
    output logic             o_v,
    input  logic             o_r,
    output logic [0:width-1] o_d,
    output logic [1:0]       o_cnt
);

    askid_state_e     state_q, state_d;
    logic [0:width-1] hd_q, hd_d;
    logic [0:width-1] sk_q, sk_d;
    logic             accept;
    logic             deliver;

    // Handshake: a beat moves on a side only in a cycle where both valid and ready are high.
    // Ready here looks only at registered state plus flush, never at o_r or i_v.
    assign i_r     = (state_q != ST_TWO) & ~flush;
    assign o_v     = (state_q != ST_EMPTY);
    assign o_d     = hd_q;
    assign o_cnt   = state_q;
    assign accept  = i_v & i_r;
    assign deliver = o_v & o_r;

    always_comb begin
        state_d = state_q;
        hd_d    = hd_q;
        sk_d    = sk_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    hd_d    = i_d;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    hd_d = i_d;
                end else if (accept) begin
                    sk_d    = i_d;
                    state_d = ST_TWO;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deliver) begin
                    hd_d    = sk_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A deliver in the flush cycle still counts as consumed downstream.
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            hd_q    <= '0;
            sk_q    <= '0;
        end else begin
            state_q <= state_d;
            hd_q    <= hd_d;
            sk_q    <= sk_d;
        end
    end

endmodule

// File: tb/tb_base_askid.sv
// Directed vector table, hand sequences and a random scoreboard run for base_askid.
module tb_base_askid;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         flush;
    logic         i_v;
    logic         i_r;
    logic [0:W-1] i_d;
    logic         o_v;
    logic         o_r;
    logic [0:W-1] o_d;
    logic [1:0]   o_cnt;

    int total;
    int bad;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         f;
        logic         iv;
        logic         orr;
        logic [W-1:0] d;
        logic         e_ov;
        logic         e_ir;
        logic [1:0]   e_cnt;
        logic [W-1:0] e_d;
    } vec_t;

    vec_t vecs[16];

    base_askid #(.width(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .i_v     (i_v),
        .i_r     (i_r),
        .i_d     (i_d),
        .o_v     (o_v),
        .o_r     (o_r),
        .o_d     (o_d),
        .o_cnt   (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic r, input logic [W-1:0] d);
        @(negedge clk);
        flush = f;
        i_v   = v;
        o_r   = r;
        i_d   = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        flush   = 1'b0;
        i_v     = 1'b0;
        o_r     = 1'b0;
        i_d     = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        flush   = 1'b0;
        i_v     = 1'b0;
        o_r     = 1'b0;
        i_d     = '0;

        // Stall / release, flush in TWO, flush in ONE, flush in EMPTY.
        //                f     iv    or    d      o_v   i_r   cnt    o_d
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h0A, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h0B, 1'b1, 1'b1, 2'd1, 8'h0A};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h0C, 1'b1, 1'b0, 2'd2, 8'h0A};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0, 2'd2, 8'h0A};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b1, 2'd1, 8'h0B};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 2'd1, 8'h0C};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 2'd1, 8'h11};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 2'd2, 8'h11};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 2'd1, 8'h44};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 2'd0, 8'h00};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h00};

        // Reset and idle
        #12;
        chk("rst_o_v", 32'(o_v), 32'd0);
        chk("rst_i_r", 32'(i_r), 32'd1);
        chk("rst_cnt", 32'(o_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("idle_o_v", 32'(o_v), 32'd0);
        chk("idle_i_r", 32'(i_r), 32'd1);
        chk("idle_cnt", 32'(o_cnt), 32'd0);

        // Vector table
        for (int k = 0; k < 16; k++) begin
            drive(vecs[k].f, vecs[k].iv, vecs[k].orr, vecs[k].d);
            chk($sformatf("vec%0d_o_v", k), 32'(o_v), 32'(vecs[k].e_ov));
            chk($sformatf("vec%0d_i_r", k), 32'(i_r), 32'(vecs[k].e_ir));
            chk($sformatf("vec%0d_cnt", k), 32'(o_cnt), 32'(vecs[k].e_cnt));
            if (vecs[k].e_ov) chk($sformatf("vec%0d_o_d", k), 32'(o_d), 32'(vecs[k].e_d));
        end

        // Streaming 0x1..0x8 with o_r held high
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(k));
            chk($sformatf("stream%0d_i_r", k), 32'(i_r), 32'd1);
            if (k > 1) begin
                chk($sformatf("stream%0d_o_v", k), 32'(o_v), 32'd1);
                chk($sformatf("stream%0d_o_d", k), 32'(o_d), 32'(k - 1));
            end else begin
                chk("stream1_o_v", 32'(o_v), 32'd0);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        chk("stream_last_o_v", 32'(o_v), 32'd1);
        chk("stream_last_o_d", 32'(o_d), 32'h8);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        chk("stream_drain_o_v", 32'(o_v), 32'd0);

        // Asynchronous reset while holding two beats
        drive(1'b0, 1'b1, 1'b0, 8'h77);
        drive(1'b0, 1'b1, 1'b0, 8'h78);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("pre_arst_cnt", 32'(o_cnt), 32'd2);
        chk("pre_arst_i_r", 32'(i_r), 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_o_v", 32'(o_v), 32'd0);
        chk("arst_i_r", 32'(i_r), 32'd1);
        chk("arst_cnt", 32'(o_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic against a depth-2 FIFO model
        exp_q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic         rv, rr, rf, m_ir, m_ov;
            logic [W-1:0] rd;
            rv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            rf = ($urandom_range(0, 63) == 0);
            rd = 8'($urandom_range(0, 255));
            drive(rf, rv, rr, rd);
            m_ov = (exp_q.size() != 0);
            m_ir = (exp_q.size() < 2) && !rf;
            chk("rnd_cnt", 32'(o_cnt), 32'(exp_q.size()));
            chk("rnd_o_v", 32'(o_v), 32'(m_ov));
            chk("rnd_i_r", 32'(i_r), 32'(m_ir));
            if (m_ov) chk("rnd_o_d", 32'(o_d), 32'(exp_q[0]));
            if (m_ov && rr) void'(exp_q.pop_front());
            if (rv && m_ir) exp_q.push_back(rd);
            if (rf) exp_q.delete();
        end

        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
